// File: rtl/text_buffer_if.sv
// Command channel for the console text buffer: valid/ready handshake plus
// the WRITE payload (column, logical row, character, colour).
interface text_buffer_if #(
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned COLOR_W = 12
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [7:0]         cmd_x;
  logic [7:0]         cmd_y;
  logic [CHAR_W-1:0]  cmd_char;
  logic [COLOR_W-1:0] cmd_color;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_char, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_char, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/text_buffer.sv
// Character/colour cell store for the VGA console with circular-row hardware
// scrolling, blank fills for CLEAR/SCROLL and a 1-cycle registered read port.
module text_buffer #(
  parameter int unsigned          COLS        = 80,
  parameter int unsigned          ROWS        = 45,
  parameter int unsigned          CHAR_W      = 8,
  parameter int unsigned          COLOR_W     = 12,
  parameter logic [CHAR_W-1:0]    BLANK_CHAR  = 8'h20,
  parameter logic [COLOR_W-1:0]   BLANK_COLOR = 12'h000,
  localparam int unsigned         ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  text_buffer_if.slave       cmd,
  input  logic [7:0]         r_pos_x,
  input  logic [7:0]         r_pos_y,
  output logic [CHAR_W-1:0]  r_char,
  output logic [COLOR_W-1:0] r_color,
  output logic               busy,
  output logic [ROW_W-1:0]   top_row
);

  localparam int unsigned DEPTH  = COLS * ROWS;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CELL_W = CHAR_W + COLOR_W;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SCROLL = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam logic [CELL_W-1:0] BLANK_CELL = {BLANK_COLOR, BLANK_CHAR};

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                accept;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [CELL_W-1:0]   wdata;
  logic                wr_in_range;
  logic                rd_in_range;
  logic [ADDR_W-1:0]   raddr;
  logic [CELL_W-1:0]   rd_data;
  logic [CELL_W-1:0]   mem [DEPTH];

  // Logical (x, y) to RAM address through the circular row offset.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [7:0] x,
                                                 input logic [7:0] y,
                                                 input logic [ROW_W-1:0] tr);
    int unsigned phys;
    phys = 32'(y) + 32'(tr);
    if (phys >= ROWS) phys = phys - ROWS;
    return ADDR_W'(phys * COLS + 32'(x));
  endfunction

  assign cmd.cmd_ready = (state == IDLE) && !reset;
  assign busy          = (state != IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign wr_in_range   = (32'(cmd.cmd_x) < COLS) && (32'(cmd.cmd_y) < ROWS);
  assign rd_in_range   = (32'(r_pos_x) < COLS) && (32'(r_pos_y) < ROWS);
  assign raddr         = map_addr(r_pos_x, r_pos_y, top_row);

  // Single RAM write port shared by host writes and blank fills.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = BLANK_CELL;
    unique case (state)
      IDLE: begin
        if (accept && cmd.cmd_op == OP_WRITE && wr_in_range) begin
          we    = 1'b1;
          waddr = map_addr(cmd.cmd_x, cmd.cmd_y, top_row);
          wdata = {cmd.cmd_color, cmd.cmd_char};
        end
      end
      CLEAR: begin
        we    = !reset;
        waddr = cnt;
      end
      SCROLL: begin
        we    = !reset;
        waddr = ADDR_W'(32'(top_row) * COLS + 32'(cnt));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      top_row <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && cmd.cmd_op == OP_SCROLL) begin
            state <= SCROLL;
            cnt   <= '0;
          end else if (accept && cmd.cmd_op == OP_CLEAR) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            top_row <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCROLL: begin
          if (cnt == ADDR_W'(COLS - 1)) begin
            top_row <= (top_row == ROW_W'(ROWS - 1)) ? '0 : top_row + 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first registered read; out-of-screen positions return a blank cell.
  always_ff @(posedge clk) begin
    if (reset)             rd_data <= '0;
    else if (!rd_in_range) rd_data <= BLANK_CELL;
    else                   rd_data <= mem[raddr];
  end

  assign r_char  = rd_data[CHAR_W-1:0];
  assign r_color = rd_data[CELL_W-1:CHAR_W];

endmodule
